// File: rtl/aes_host_master_if.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_host_master_if: job request/response and AES core register port
// Rev 1.0
// ------------------------------------------------------------------
interface aes_host_master_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_op;
  logic [1:0]   req_keylen;
  logic         req_keep_key;
  logic [255:0] req_key;
  logic [127:0] req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [7:0]   DIN;
  logic [6:0]   ADDR;
  logic         WR;
  logic         START;
  logic         OK;
  logic [7:0]   DOUT;

  modport master (
    input  req_valid, req_op, req_keylen, req_keep_key, req_key, req_data,
    input  rsp_ready, OK, DOUT,
    output req_ready, rsp_valid, rsp_data, rsp_err, DIN, ADDR, WR, START
  );

  modport slave (
    output req_valid, req_op, req_keylen, req_keep_key, req_key, req_data,
    output rsp_ready, OK, DOUT,
    input  req_ready, rsp_valid, rsp_data, rsp_err, DIN, ADDR, WR, START
  );
endinterface
`default_nettype wire

// File: rtl/aes_host_master.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_host_master: serialises one AES block job onto the core byte port
// Rev 1.0
// ------------------------------------------------------------------
module aes_host_master #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int RD_LAT      = 1
) (
  input  logic               CLK,
  input  logic               RST,
  aes_host_master_if.master  bus
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(RD_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_KEY, WR_DATA, WR_CFG, START_P, START_GAP,
    WAIT_OK, RD_ADDR, RD_WAIT, RESP
  } state_t;

  state_t         state;
  logic           op;
  logic [1:0]     keylen;
  logic [255:0]   key_sh;
  logic [127:0]   data_sh;
  logic [4:0]     idx;
  logic [4:0]     key_last;
  logic [TW-1:0]  tcnt;
  logic [LW-1:0]  lcnt;
  logic [3:0]     rd_idx;

  always_comb begin
    key_last = 5'd15;
    case (keylen)
      2'd1:    key_last = 5'd23;
      2'd2:    key_last = 5'd31;
      default: key_last = 5'd15;
    endcase
  end

  // Key and data go out MSB byte first, so both are kept as left-shifting registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      bus.WR        <= 1'b0;
      bus.START     <= 1'b0;
      bus.DIN       <= '0;
      bus.ADDR      <= '0;
      op            <= 1'b0;
      keylen        <= '0;
      key_sh        <= '0;
      data_sh       <= '0;
      idx           <= '0;
      tcnt          <= '0;
      lcnt          <= '0;
      rd_idx        <= '0;
    end else begin
      bus.WR    <= 1'b0;
      bus.START <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            op            <= bus.req_op;
            keylen        <= bus.req_keylen;
            idx           <= '0;
            if (bus.req_keylen == 2'd3) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end else if (bus.req_keep_key) begin
              state    <= WR_DATA;
              bus.WR   <= 1'b1;
              bus.ADDR <= 7'h00;
              bus.DIN  <= bus.req_data[127:120];
              data_sh  <= bus.req_data << 8;
            end else begin
              state    <= WR_KEY;
              bus.WR   <= 1'b1;
              bus.ADDR <= 7'h10;
              bus.DIN  <= bus.req_key[255:248];
              key_sh   <= bus.req_key << 8;
              data_sh  <= bus.req_data;
            end
          end
        end
        WR_KEY: begin
          bus.WR <= 1'b1;
          if (idx == key_last) begin
            state    <= WR_DATA;
            idx      <= '0;
            bus.ADDR <= 7'h00;
            bus.DIN  <= data_sh[127:120];
            data_sh  <= data_sh << 8;
          end else begin
            idx      <= idx + 5'd1;
            bus.ADDR <= 7'h10 + 7'(idx) + 7'd1;
            bus.DIN  <= key_sh[255:248];
            key_sh   <= key_sh << 8;
          end
        end
        WR_DATA: begin
          bus.WR <= 1'b1;
          if (idx == 5'd15) begin
            state    <= WR_CFG;
            bus.ADDR <= 7'h30;
            bus.DIN  <= {5'b0, keylen, op};
          end else begin
            idx      <= idx + 5'd1;
            bus.ADDR <= 7'(idx) + 7'd1;
            bus.DIN  <= data_sh[127:120];
            data_sh  <= data_sh << 8;
          end
        end
        WR_CFG: begin
          state     <= START_P;
          bus.START <= 1'b1;
        end
        START_P: begin
          state <= START_GAP;
        end
        START_GAP: begin
          state <= WAIT_OK;
          tcnt  <= '0;
        end
        WAIT_OK: begin
          // OK takes priority over a timeout landing in the same cycle.
          if (bus.OK) begin
            state    <= RD_ADDR;
            rd_idx   <= '0;
            bus.ADDR <= 7'h40;
          end else if (tcnt == T_LAST) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_data  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RD_ADDR: begin
          state <= RD_WAIT;
          lcnt  <= '0;
        end
        RD_WAIT: begin
          if (lcnt == L_LAST) begin
            bus.rsp_data <= {bus.rsp_data[119:0], bus.DOUT};
            if (rd_idx == 4'd15) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
            end else begin
              state    <= RD_ADDR;
              rd_idx   <= rd_idx + 4'd1;
              bus.ADDR <= 7'h40 + 7'(rd_idx) + 7'd1;
            end
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
